// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// IJTAG test data register for the gate1 19-bit data mux: capture, shift, length-checked update.
// Build option FIREBIRD7_TDR_CAPTURE_EN: capture observes functional_data_in instead of reading back ur.
module firebird7_in_gate1_tessent_tdr_w19_ctl #(
  parameter int DATA_W = 19,
  parameter int CNT_W  = 6
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [DATA_W-1:0] functional_data_in,
  output logic [DATA_W-1:0] ijtag_data_out,
  output logic              ijtag_select_out,
  output logic              length_err
);

  localparam int SR_W = DATA_W + 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CAPTURE,
    OP_SHIFT,
    OP_UPDATE
  } op_e;

  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  r_ur;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  op_e              w_op;
  logic [SR_W-1:0]  w_capture;
  logic             w_len_ok;
  logic [SR_W-1:0]  w_sr_nxt;
  logic [SR_W-1:0]  w_ur_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;

`ifdef FIREBIRD7_TDR_CAPTURE_EN
  assign w_capture = {r_ur[DATA_W], functional_data_in};
`else
  logic w_unused_func;
  assign w_capture     = r_ur;
  assign w_unused_func = ^functional_data_in;
`endif

  // A full-length shift leaves exactly one bit per register position.
  assign w_len_ok = (r_cnt == CNT_W'(SR_W));

  always_comb begin
    w_op = OP_HOLD;
    if (ijtag_sel) begin
      if (ijtag_ce)      w_op = OP_CAPTURE;
      else if (ijtag_se) w_op = OP_SHIFT;
      else if (ijtag_ue) w_op = OP_UPDATE;
    end
  end

  // NOTE: every variable gets a default before the case, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_sr_nxt  = r_sr;
    w_ur_nxt  = r_ur;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    unique case (w_op)
      OP_CAPTURE: begin
        w_sr_nxt  = w_capture;
        w_cnt_nxt = '0;
      end
      OP_SHIFT: begin
        w_sr_nxt  = {ijtag_si, r_sr[DATA_W:1]};
        w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      end
      OP_UPDATE: begin
        if (w_len_ok) w_ur_nxt  = r_sr;
        else          w_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_sr  <= '0;
      r_ur  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_sr  <= w_sr_nxt;
      r_ur  <= w_ur_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign ijtag_so         = r_sr[0];
  assign ijtag_data_out   = r_ur[DATA_W-1:0];
  assign ijtag_select_out = r_ur[DATA_W];
  assign length_err       = r_err;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// Directed bench for the gate1 IJTAG TDR; expectations follow the build selected by FIREBIRD7_TDR_CAPTURE_EN.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctl;

  localparam int DATA_W = 19;

  logic              ijtag_tck = 1'b0;
  logic              ijtag_reset;
  logic              ijtag_sel;
  logic              ijtag_ce;
  logic              ijtag_se;
  logic              ijtag_ue;
  logic              ijtag_si;
  logic              ijtag_so;
  logic [DATA_W-1:0] functional_data_in;
  logic [DATA_W-1:0] ijtag_data_out;
  logic              ijtag_select_out;
  logic              length_err;

  int n_pass  = 0;
  int n_total = 0;

  firebird7_in_gate1_tessent_tdr_w19_ctl dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .ijtag_data_out     (ijtag_data_out),
    .ijtag_select_out   (ijtag_select_out),
    .length_err         (length_err)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic do_capture();
    ijtag_ce = 1'b1;
    tick();
    ijtag_ce = 1'b0;
  endtask

  task automatic do_update();
    ijtag_ue = 1'b1;
    tick();
    ijtag_ue = 1'b0;
  endtask

  // Shifts w LSB first; positions past bit 19 shift in zeros.
  task automatic shift_bits(input logic [DATA_W:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ijtag_si = (i <= DATA_W) ? w[i] : 1'b0;
      ijtag_se = 1'b1;
      tick();
    end
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic apply_reset();
    ijtag_reset = 1'b1;
    tick();
    ijtag_reset = 1'b0;
  endtask

  task automatic test_reset();
    ijtag_reset = 1'b1;
    tick();
    tick();
    ijtag_reset = 1'b0;
    n_total++; if (ijtag_data_out !== 19'h0) $display("FAIL reset_data: got %h expected %h", ijtag_data_out, 19'h0); else n_pass++;
    n_total++; if (ijtag_select_out !== 1'b0) $display("FAIL reset_select: got %b expected 0", ijtag_select_out); else n_pass++;
    n_total++; if (ijtag_so !== 1'b0) $display("FAIL reset_so: got %b expected 0", ijtag_so); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", length_err); else n_pass++;
  endtask

  task automatic test_load();
    do_capture();
    shift_bits({1'b1, 19'h5A5A5}, 20);
    n_total++; if (ijtag_data_out !== 19'h0) $display("FAIL load_before_update: got %h expected %h", ijtag_data_out, 19'h0); else n_pass++;
    do_update();
    n_total++; if (ijtag_select_out !== 1'b1) $display("FAIL load_select: got %b expected 1", ijtag_select_out); else n_pass++;
    n_total++; if (ijtag_data_out !== 19'h5A5A5) $display("FAIL load_data: got %h expected %h", ijtag_data_out, 19'h5A5A5); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL load_err: got %b expected 0", length_err); else n_pass++;
  endtask

  // Runs right after test_load, so ur holds {1, 19'h5A5A5}.
  task automatic test_capture();
    logic [DATA_W:0] exp;
    functional_data_in = 19'h7FFFF;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    exp = {1'b1, 19'h7FFFF};
`else
    exp = {1'b1, 19'h5A5A5};
`endif
    do_capture();
    for (int i = 0; i <= DATA_W; i++) begin
      n_total++; if (ijtag_so !== exp[i]) $display("FAIL capture_so[%0d]: got %b expected %b", i, ijtag_so, exp[i]); else n_pass++;
      shift_bits('0, 1);
    end
  endtask

  // ce+se+ue together must only capture and clear cnt; a following 20-shift load must then succeed.
  task automatic test_priority();
    logic so_exp;
    functional_data_in = 19'h00002;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    so_exp = 1'b0;
`else
    so_exp = 1'b1;
`endif
    do_capture();
    shift_bits({1'b0, 19'h12344}, 20);
    ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b1;
    tick();
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    n_total++; if (ijtag_data_out !== 19'h5A5A5) $display("FAIL prio_no_update: got %h expected %h", ijtag_data_out, 19'h5A5A5); else n_pass++;
    n_total++; if (ijtag_so !== so_exp) $display("FAIL prio_capture_so: got %b expected %b", ijtag_so, so_exp); else n_pass++;
    shift_bits({1'b0, 19'h0F0F0}, 20);
    do_update();
    n_total++; if (ijtag_data_out !== 19'h0F0F0) $display("FAIL prio_cnt_cleared_data: got %h expected %h", ijtag_data_out, 19'h0F0F0); else n_pass++;
    n_total++; if (ijtag_select_out !== 1'b0) $display("FAIL prio_select: got %b expected 0", ijtag_select_out); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL prio_err: got %b expected 0", length_err); else n_pass++;
  endtask

  task automatic test_gating();
    do_capture();
    shift_bits({1'b1, 19'h3C3C1}, 20);
    ijtag_sel = 1'b0;
    ijtag_si  = 1'b1;
    ijtag_se  = 1'b1;
    tick(); tick(); tick();
    ijtag_se = 1'b0;
    do_capture();
    do_update();
    n_total++; if (ijtag_so !== 1'b1) $display("FAIL gate_so: got %b expected 1", ijtag_so); else n_pass++;
    n_total++; if (ijtag_data_out !== 19'h0F0F0) $display("FAIL gate_data: got %h expected %h", ijtag_data_out, 19'h0F0F0); else n_pass++;
    ijtag_sel = 1'b1;
    ijtag_si  = 1'b0;
    do_update();
    n_total++; if (ijtag_data_out !== 19'h3C3C1) $display("FAIL gate_cnt_held_data: got %h expected %h", ijtag_data_out, 19'h3C3C1); else n_pass++;
    n_total++; if (ijtag_select_out !== 1'b1) $display("FAIL gate_select: got %b expected 1", ijtag_select_out); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL gate_err: got %b expected 0", length_err); else n_pass++;
  endtask

  task automatic test_short_shift();
    do_capture();
    shift_bits({1'b0, 19'h11111}, 19);
    do_update();
    n_total++; if (ijtag_data_out !== 19'h3C3C1) $display("FAIL short_ur_held: got %h expected %h", ijtag_data_out, 19'h3C3C1); else n_pass++;
    n_total++; if (length_err !== 1'b1) $display("FAIL short_err: got %b expected 1", length_err); else n_pass++;
    do_capture();
    shift_bits({1'b0, 19'h54321}, 20);
    do_update();
    n_total++; if (ijtag_data_out !== 19'h54321) $display("FAIL short_reload_data: got %h expected %h", ijtag_data_out, 19'h54321); else n_pass++;
    n_total++; if (length_err !== 1'b1) $display("FAIL short_err_sticky: got %b expected 1", length_err); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    do_capture();
    shift_bits(20'hFFFFF, 3);
    ijtag_se = 1'b1; ijtag_ce = 1'b1; ijtag_si = 1'b1; ijtag_reset = 1'b1;
    tick();
    ijtag_se = 1'b0; ijtag_ce = 1'b0; ijtag_si = 1'b0; ijtag_reset = 1'b0;
    n_total++; if (ijtag_data_out !== 19'h0) $display("FAIL midreset_data: got %h expected %h", ijtag_data_out, 19'h0); else n_pass++;
    n_total++; if (ijtag_select_out !== 1'b0) $display("FAIL midreset_select: got %b expected 0", ijtag_select_out); else n_pass++;
    n_total++; if (ijtag_so !== 1'b0) $display("FAIL midreset_so: got %b expected 0", ijtag_so); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL midreset_err: got %b expected 0", length_err); else n_pass++;
  endtask

  task automatic test_zero_shift();
    functional_data_in = 19'h7FFFF;
    do_capture();
    do_update();
    n_total++; if (length_err !== 1'b1) $display("FAIL zero_shift_err: got %b expected 1", length_err); else n_pass++;
    n_total++; if (ijtag_data_out !== 19'h0) $display("FAIL zero_shift_ur_held: got %h expected %h", ijtag_data_out, 19'h0); else n_pass++;
  endtask

  task automatic test_over_shift();
    apply_reset();
    do_capture();
    shift_bits(20'h00001, 1);
    shift_bits({1'b1, 19'h2AAAA}, 20);
    do_update();
    n_total++; if (length_err !== 1'b1) $display("FAIL over_shift_err: got %b expected 1", length_err); else n_pass++;
    n_total++; if (ijtag_data_out !== 19'h0) $display("FAIL over_shift_ur_held: got %h expected %h", ijtag_data_out, 19'h0); else n_pass++;
    apply_reset();
    do_capture();
    shift_bits('0, 70);
    do_update();
    n_total++; if (length_err !== 1'b1) $display("FAIL saturate_err: got %b expected 1", length_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_capture();
    shift_bits({1'b1, 19'h6DB6D}, 20);
    ijtag_ue = 1'b1;
    tick();
    n_total++; if (ijtag_data_out !== 19'h6DB6D) $display("FAIL b2b_first_data: got %h expected %h", ijtag_data_out, 19'h6DB6D); else n_pass++;
    tick();
    ijtag_ue = 1'b0;
    n_total++; if (ijtag_data_out !== 19'h6DB6D) $display("FAIL b2b_second_data: got %h expected %h", ijtag_data_out, 19'h6DB6D); else n_pass++;
    n_total++; if (ijtag_select_out !== 1'b1) $display("FAIL b2b_select: got %b expected 1", ijtag_select_out); else n_pass++;
    n_total++; if (length_err !== 1'b0) $display("FAIL b2b_err: got %b expected 0", length_err); else n_pass++;
  endtask

  initial begin
    ijtag_reset        = 1'b1;
    ijtag_sel          = 1'b1;
    ijtag_ce           = 1'b0;
    ijtag_se           = 1'b0;
    ijtag_ue           = 1'b0;
    ijtag_si           = 1'b0;
    functional_data_in = '0;
    test_reset();
    test_load();
    test_capture();
    test_priority();
    test_gating();
    test_short_shift();
    test_reset_mid_shift();
    test_zero_shift();
    test_over_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
